// File: rtl/multi_strob_gen.sv
// Multi-channel system strobe generator.
// A shared epoch grid (integer period plus fractional offset, after a start delay) drives
// CHANNELS strobe outputs. Each channel jitters its strobe inside a clamped window and
// may drop it with a programmable loss probability, using its own Galois LFSR.
module multi_strob_gen #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned FRAC_W   = 16,
  parameter logic [31:0] SEED     = 32'h1ACE_B00C
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ce,
  input  logic                start,
  input  logic                stop,
  input  logic [CNT_W-1:0]    period,
  input  logic [FRAC_W-1:0]   period_frac,
  input  logic [CNT_W-1:0]    start_delay,
  input  logic [15:0]         error_val,
  input  logic [15:0]         p_loss,
  input  logic [CHANNELS-1:0] ch_en,
  output logic [CHANNELS-1:0] strob,
  output logic [CHANNELS-1:0] lost,
  output logic                epoch,
  output logic                running
);

  typedef enum logic [1:0] {StIdle, StDelay, StRun} state_e;

  // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form).
  localparam logic [31:0] LfsrMask = 32'h8020_0003;

  function automatic logic [31:0] chan_seed(input int unsigned ch);
    logic [31:0] s;
    s = SEED ^ (32'(ch) * 32'h9E37_79B9);
    if (s == 32'd0) s = 32'd1;
    return s;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ LfsrMask) : (x >> 1);
  endfunction

  state_e              state_q;
  logic [CNT_W-1:0]    dly_q;
  logic [CNT_W-1:0]    per_q;
  logic [FRAC_W-1:0]   frac_acc_q;
  logic [CNT_W-1:0]    period_q;
  logic [FRAC_W-1:0]   frac_q;
  logic [15:0]         err_q;
  logic [15:0]         ploss_q;
  logic [CHANNELS-1:0] chen_q;
  logic [31:0]         lfsr_q [CHANNELS];
  logic [15:0]         pend_q [CHANNELS];
  logic [CHANNELS-1:0] pend_vld_q;

  logic [CNT_W-1:0]    p_eff;
  logic [CNT_W-1:0]    p_m1;
  logic [15:0]         eff_err;
  logic [FRAC_W:0]     frac_sum;
  logic                epoch_now;
  logic [CHANNELS-1:0] loss;
  logic [15:0]         off [CHANNELS];

  // Derived timing values and per-channel draws from the current LFSR state.
  always_comb begin
    p_eff     = (period_q == '0) ? CNT_W'(1) : period_q;
    p_m1      = p_eff - CNT_W'(1);
    // Window never reaches the next epoch, so a pending strobe always drains first.
    eff_err   = (p_m1 < CNT_W'(err_q)) ? p_m1[15:0] : err_q;
    frac_sum  = {1'b0, frac_acc_q} + {1'b0, frac_q};
    epoch_now = ((state_q == StDelay) && (dly_q == '0)) ||
                ((state_q == StRun) && (per_q == '0));
    loss      = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      loss[i] = (ploss_q == 16'hFFFF) || (lfsr_q[i][15:0] < ploss_q);
      off[i]  = 16'((33'(lfsr_q[i][31:16]) * (33'(eff_err) + 33'd1)) >> 16);
    end
  end

  // Control FSM, epoch grid, per-channel pending countdowns and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      dly_q      <= '0;
      per_q      <= '0;
      frac_acc_q <= '0;
      period_q   <= '0;
      frac_q     <= '0;
      err_q      <= '0;
      ploss_q    <= '0;
      chen_q     <= '0;
      pend_vld_q <= '0;
      strob      <= '0;
      lost       <= '0;
      epoch      <= 1'b0;
      running    <= 1'b0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        lfsr_q[i] <= chan_seed(i);
        pend_q[i] <= '0;
      end
    end else begin
      strob <= '0;
      lost  <= '0;
      epoch <= 1'b0;
      if (stop) begin
        state_q    <= StIdle;
        running    <= 1'b0;
        pend_vld_q <= '0;
      end else if (start) begin
        state_q    <= StDelay;
        running    <= 1'b1;
        period_q   <= period;
        frac_q     <= period_frac;
        err_q      <= error_val;
        ploss_q    <= p_loss;
        chen_q     <= ch_en;
        dly_q      <= start_delay;
        frac_acc_q <= '0;
        pend_vld_q <= '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
          lfsr_q[i] <= chan_seed(i);
        end
      end else if (ce && (state_q != StIdle)) begin
        for (int i = 0; i < int'(CHANNELS); i++) begin
          lfsr_q[i] <= lfsr_step(lfsr_q[i]);
          if (pend_vld_q[i]) begin
            if (pend_q[i] == '0) begin
              strob[i]      <= 1'b1;
              pend_vld_q[i] <= 1'b0;
            end else begin
              pend_q[i] <= pend_q[i] - 16'd1;
            end
          end
        end
        if (epoch_now) begin
          epoch      <= 1'b1;
          state_q    <= StRun;
          frac_acc_q <= frac_sum[FRAC_W-1:0];
          per_q      <= p_m1 + CNT_W'(frac_sum[FRAC_W]);
          for (int i = 0; i < int'(CHANNELS); i++) begin
            if (chen_q[i]) begin
              if (loss[i]) begin
                lost[i] <= 1'b1;
              end else if (off[i] == '0) begin
                strob[i] <= 1'b1;
              end else begin
                // Counting down off-1 lands the pulse exactly off ce edges after the epoch.
                pend_vld_q[i] <= 1'b1;
                pend_q[i]     <= off[i] - 16'd1;
              end
            end
          end
        end else if (state_q == StDelay) begin
          dly_q <= dly_q - CNT_W'(1);
        end else begin
          per_q <= per_q - CNT_W'(1);
        end
      end
    end
  end

endmodule
